// File: rtl/nibble_serial_addsub_ctrl_if.sv
// rtl/nibble_serial_addsub_ctrl_if.sv - operand/result bundle for the nibble-serial add/sub sequencer
interface nibble_serial_addsub_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  modport master (
    output start, op, a, b,
    input  ready, busy, done, result, cout, ovf
  );

  modport slave (
    input  start, op, a, b,
    output ready, busy, done, result, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// rtl/nibble_serial_addsub_ctrl.sv - wide add/sub stepped through one 4-bit slice, LSB nibble first
module nibble_serial_addsub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  nibble_serial_addsub_ctrl_if.slave  io_bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_op;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic [W-1:0]  r_result;
  logic          r_cout;
  logic          r_ovf;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;

  logic [3:0]    w_a_nib;
  logic [3:0]    w_b_nib;
  logic [4:0]    w_sum;
  logic          w_ovf;

  // The single 4-bit slice; b is inverted and carry_reg seeded with op for subtract.
  assign w_a_nib = r_a[{r_cnt, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_cnt, 2'b00} +: 4] ^ {4{r_op}};
  assign w_sum   = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
  assign w_ovf   = (w_a_nib[3] == w_b_nib[3]) && (w_sum[3] != w_a_nib[3]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 1'b0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (io_bus.start) begin
            r_state  <= S_RUN;
            r_a      <= io_bus.a;
            r_b      <= io_bus.b;
            r_op     <= io_bus.op;
            r_cnt    <= '0;
            r_carry  <= io_bus.op;
            r_result <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
          end else begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
          end
        end
        S_RUN: begin
          r_result[{r_cnt, 2'b00} +: 4] <= w_sum[3:0];
          r_carry <= w_sum[4];
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
            r_cout  <= w_sum[4];
            r_ovf   <= w_ovf;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.ready  = r_ready;
  assign io_bus.busy   = r_busy;
  assign io_bus.done   = r_done;
  assign io_bus.result = r_result;
  assign io_bus.cout   = r_cout;
  assign io_bus.ovf    = r_ovf;
endmodule
